// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
// SPI_FAST_READ_EN selects the 0x0B fast-read opcode with a 5-byte header.
package spi_flash_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StSsoOn,
    StWaitTrdy,
    StWrTx,
    StWaitRrdy,
    StRdRx,
    StEmit,
    StSsoOff,
    StDone
  } state_e;

  localparam logic [2:0]  REG_RX   = 3'd0;
  localparam logic [2:0]  REG_TX   = 3'd1;
  localparam logic [2:0]  REG_CTRL = 3'd3;
  localparam logic [15:0] CTRL_SSO = 16'h0400;

  localparam logic [7:0]  FAST_READ_OPCODE = 8'h0B;

`ifdef SPI_FAST_READ_EN
  localparam logic [2:0]  HDR_LEN = 3'd5;
`else
  localparam logic [2:0]  HDR_LEN = 3'd4;
`endif

  // Header byte by index; the fast-read dummy (index 4) falls through to zero.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  opcode,
                                          input logic [23:0] addr);
    logic [7:0] b;
    case (idx)
      3'd0:    b = opcode;
      3'd1:    b = addr[23:16];
      3'd2:    b = addr[15:8];
      3'd3:    b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_reg_access.sv
// Two-cycle register-port access engine for the Avalon-style SPI core.
// Each request holds the bus for exactly two cycles, then acks with one idle cycle.
module spi_reg_access
  import spi_flash_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_addr,
  input  logic [15:0] i_wdata,
  output logic        o_ack,
  output logic [7:0]  o_rdata,
  output logic        o_spi_select,
  output logic [2:0]  o_spi_mem_addr,
  output logic        o_spi_read_n,
  output logic        o_spi_write_n,
  output logic [15:0] o_spi_data_from_cpu,
  input  logic [7:0]  i_spi_data_to_cpu
);

  logic        r_sel;
  logic        r_rd_n;
  logic        r_wr_n;
  logic [2:0]  r_addr;
  logic [15:0] r_wdata;
  logic        r_cnt;
  logic        r_ack;
  logic [7:0]  r_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sel   <= 1'b0;
      r_rd_n  <= 1'b1;
      r_wr_n  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= 1'b0;
      if (r_sel) begin
        if (r_cnt) begin
          r_sel   <= 1'b0;
          r_rd_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_addr  <= '0;
          r_wdata <= '0;
          r_cnt   <= 1'b0;
          r_ack   <= 1'b1;
          if (!r_rd_n) r_rdata <= i_spi_data_to_cpu;
        end else begin
          r_cnt <= 1'b1;
        end
      end else if (i_req && !r_ack) begin
        // Blocking on r_ack guarantees the idle gap while the requester reacts.
        r_sel   <= 1'b1;
        r_rd_n  <= i_we;
        r_wr_n  <= ~i_we;
        r_addr  <= i_addr;
        r_wdata <= i_we ? i_wdata : 16'h0000;
        r_cnt   <= 1'b0;
      end
    end
  end

  assign o_ack               = r_ack;
  assign o_rdata             = r_rdata;
  assign o_spi_select        = r_sel;
  assign o_spi_mem_addr      = r_addr;
  assign o_spi_read_n        = r_rd_n;
  assign o_spi_write_n       = r_wr_n;
  assign o_spi_data_from_cpu = r_wdata;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: SSO on, opcode + address, N payload bytes streamed, SSO off.
// Build with SPI_FAST_READ_EN for the 0x0B fast-read header (opcode, address, one dummy).
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned LEN_W       = 16,
  parameter logic [7:0]  READ_OPCODE = 8'h03
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [23:0]      i_flash_addr,
  input  logic [LEN_W-1:0] i_length,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_spi_select,
  output logic [2:0]       o_spi_mem_addr,
  output logic             o_spi_read_n,
  output logic             o_spi_write_n,
  output logic [15:0]      o_spi_data_from_cpu,
  input  logic [15:0]      i_spi_data_to_cpu,
  input  logic             i_spi_dataavailable,
  input  logic             i_spi_readyfordata
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPCODE = FAST_READ_OPCODE;
  logic w_unused;
  assign w_unused = ^{i_spi_data_to_cpu[15:8], READ_OPCODE};
`else
  localparam logic [7:0] OPCODE = READ_OPCODE;
  logic w_unused;
  assign w_unused = ^i_spi_data_to_cpu[15:8];
`endif

  state_e           r_state;
  state_e           w_state_next;
  logic [23:0]      r_addr;
  logic [LEN_W-1:0] r_remaining;
  logic [2:0]       r_hdr;
  logic [7:0]       r_out_data;

  logic        w_req;
  logic        w_we;
  logic [2:0]  w_addr;
  logic [15:0] w_wdata;
  logic        w_ack;
  logic [7:0]  w_rdata;
  logic        w_in_hdr;
  logic        w_latch;
  logic        w_hdr_clr;
  logic        w_hdr_inc;
  logic        w_load_data;
  logic        w_cnt_dec;

  assign w_in_hdr = (r_hdr < HDR_LEN);

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = REG_RX;
    w_wdata      = 16'h0000;
    w_latch      = 1'b0;
    w_hdr_clr    = 1'b0;
    w_hdr_inc    = 1'b0;
    w_load_data  = 1'b0;
    w_cnt_dec    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_latch      = 1'b1;
          w_state_next = (i_length == '0) ? StDone : StSsoOn;
        end
      end
      StSsoOn: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = REG_CTRL;
        w_wdata = CTRL_SSO;
        if (w_ack) begin
          w_hdr_clr    = 1'b1;
          w_state_next = StWaitTrdy;
        end
      end
      StWaitTrdy: begin
        if (i_spi_readyfordata) w_state_next = StWrTx;
      end
      StWrTx: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = REG_TX;
        w_wdata = {8'h00, w_in_hdr ? hdr_byte(r_hdr, OPCODE, r_addr) : 8'h00};
        if (w_ack) w_state_next = StWaitRrdy;
      end
      StWaitRrdy: begin
        if (i_spi_dataavailable) w_state_next = StRdRx;
      end
      StRdRx: begin
        w_req  = 1'b1;
        w_addr = REG_RX;
        if (w_ack) begin
          if (w_in_hdr) begin
            w_hdr_inc    = 1'b1;
            w_state_next = StWaitTrdy;
          end else begin
            w_load_data  = 1'b1;
            w_state_next = StEmit;
          end
        end
      end
      StEmit: begin
        // No new TX write is issued until the current byte is accepted.
        if (i_out_ready) begin
          w_cnt_dec    = 1'b1;
          w_state_next = (r_remaining == LEN_W'(1)) ? StSsoOff : StWaitTrdy;
        end
      end
      StSsoOff: begin
        w_req   = 1'b1;
        w_we    = 1'b1;
        w_addr  = REG_CTRL;
        w_wdata = 16'h0000;
        if (w_ack) w_state_next = StDone;
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_remaining <= '0;
      r_hdr       <= '0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_addr      <= i_flash_addr;
        r_remaining <= i_length;
      end
      if (w_hdr_clr) begin
        r_hdr <= '0;
      end else if (w_hdr_inc) begin
        r_hdr <= r_hdr + 3'd1;
      end
      if (w_load_data) r_out_data <= w_rdata;
      if (w_cnt_dec) r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  assign o_busy      = (r_state != StIdle) && (r_state != StDone);
  assign o_done      = (r_state == StDone);
  assign o_out_valid = (r_state == StEmit);
  assign o_out_data  = r_out_data;

  spi_reg_access u_reg_access (
    .i_clk               (i_clk),
    .i_reset_n           (i_reset_n),
    .i_req               (w_req),
    .i_we                (w_we),
    .i_addr              (w_addr),
    .i_wdata             (w_wdata),
    .o_ack               (w_ack),
    .o_rdata             (w_rdata),
    .o_spi_select        (o_spi_select),
    .o_spi_mem_addr      (o_spi_mem_addr),
    .o_spi_read_n        (o_spi_read_n),
    .o_spi_write_n       (o_spi_write_n),
    .o_spi_data_from_cpu (o_spi_data_from_cpu),
    .i_spi_data_to_cpu   (i_spi_data_to_cpu[7:0])
  );

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: SPI core + flash model, table-driven transfers, corner sequences.
module tb_spi_flash_reader;

`ifdef SPI_FAST_READ_EN
  localparam int         HDR = 5;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int         HDR = 4;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [23:0] flash_addr;
  logic [15:0] length;
  logic        busy, done, out_valid, out_ready;
  logic [7:0]  out_data;
  logic        spi_select, spi_read_n, spi_write_n;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_data_from_cpu;
  logic [15:0] spi_data_to_cpu;

  always #5 clk = ~clk;

  // SPI core + flash model state
  logic       m_trdy, m_rrdy, m_sso, m_toe, m_roe, m_ss_err, m_prev_sel;
  logic [7:0] m_rx;
  int         m_shift, m_xidx, m_tx_writes, m_sel_cycles, m_done_cnt;
  logic [7:0] flash_base;
  logic [7:0] mosi_q[$];
  logic [7:0] got_q[$];

  assign spi_data_to_cpu = {8'h00, m_rx};

  spi_flash_reader dut (
    .i_clk               (clk),
    .i_reset_n           (reset_n),
    .i_start             (start),
    .i_flash_addr        (flash_addr),
    .i_length            (length),
    .o_busy              (busy),
    .o_done              (done),
    .o_out_data          (out_data),
    .o_out_valid         (out_valid),
    .i_out_ready         (out_ready),
    .o_spi_select        (spi_select),
    .o_spi_mem_addr      (spi_mem_addr),
    .o_spi_read_n        (spi_read_n),
    .o_spi_write_n       (spi_write_n),
    .o_spi_data_from_cpu (spi_data_from_cpu),
    .i_spi_data_to_cpu   (spi_data_to_cpu),
    .i_spi_dataavailable (m_rrdy),
    .i_spi_readyfordata  (m_trdy)
  );

  initial begin
    m_tx_writes  = 0;
    m_sel_cycles = 0;
    m_done_cnt   = 0;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      m_trdy <= 1'b1; m_rrdy <= 1'b0; m_sso <= 1'b0; m_toe <= 1'b0; m_roe <= 1'b0;
      m_ss_err <= 1'b0; m_prev_sel <= 1'b0; m_rx <= 8'h00; m_shift <= 0; m_xidx <= 0;
    end else begin
      m_prev_sel <= spi_select;
      if (spi_select) m_sel_cycles <= m_sel_cycles + 1;
      if (done) m_done_cnt <= m_done_cnt + 1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (spi_select && !m_prev_sel) begin
        if (!spi_write_n && spi_mem_addr == 3'd3) begin
          m_sso <= spi_data_from_cpu[10];
          if (spi_data_from_cpu[10]) m_xidx <= 0;
        end else if (!spi_write_n && spi_mem_addr == 3'd1) begin
          if (!m_trdy) m_toe <= 1'b1;
          if (!m_sso) m_ss_err <= 1'b1;
          mosi_q.push_back(spi_data_from_cpu[7:0]);
          m_tx_writes <= m_tx_writes + 1;
          m_trdy  <= 1'b0;
          m_shift <= 6;
        end else if (!spi_read_n && spi_mem_addr == 3'd0) begin
          m_rrdy <= 1'b0;
        end
      end
      if (m_shift != 0) begin
        m_shift <= m_shift - 1;
        if (m_shift == 1) begin
          if (m_rrdy) m_roe <= 1'b1;
          m_rx   <= (m_xidx < HDR) ? 8'hFF : flash_base + 8'(m_xidx - HDR);
          m_xidx <= m_xidx + 1;
          m_rrdy <= 1'b1;
          m_trdy <= 1'b1;
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    int          len;
    logic [7:0]  base;
    int          stall_idx;
    int          stall_cyc;
    bit          extra_start;
    logic [39:0] exp_hdr;
  } vec_t;

  task automatic do_xfer(input vec_t v);
    int   g0, m0, d0, cyc, stall_left, tx_at_stall, bad;
    bit   stalling, stall_done;
    g0 = got_q.size(); m0 = mosi_q.size(); d0 = m_done_cnt;
    cyc = 0; stall_left = v.stall_cyc; tx_at_stall = 0; stalling = 0; stall_done = 0;
    flash_base = v.base;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    flash_addr = v.addr; length = 16'(v.len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (m_done_cnt == d0 && cyc < 3000) begin
      start = 1'b0;
      if (v.extra_start && (cyc == 20 || done)) begin
        start = 1'b1; length = 16'd7;
      end
      if (v.stall_cyc > 0 && out_valid && (got_q.size() - g0) == v.stall_idx && stall_left > 0) begin
        if (!stalling) tx_at_stall = m_tx_writes;
        stalling = 1; out_ready = 1'b0; stall_left--;
      end else begin
        if (stalling && !stall_done) begin
          chk("stall_no_tx", 64'(m_tx_writes - tx_at_stall), 64'd0);
          chk("stall_valid_held", 64'(out_valid), 64'd1);
          stall_done = 1;
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("busy_after_done", 64'(busy), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("done_pulses", 64'(m_done_cnt - d0), 64'd1);
    chk("byte_count", 64'(got_q.size() - g0), 64'(v.len));
    for (int k = 0; k < v.len && (g0 + k) < got_q.size(); k++)
      chk($sformatf("payload[%0d]", k), 64'(got_q[g0 + k]), 64'(v.base + 8'(k)));
    chk("mosi_count", 64'(mosi_q.size() - m0), 64'(HDR + v.len));
    for (int i = 0; i < HDR && (m0 + i) < mosi_q.size(); i++)
      chk($sformatf("mosi_hdr[%0d]", i), 64'(mosi_q[m0 + i]), 64'(v.exp_hdr[39 - 8*i -: 8]));
    bad = 0;
    for (int i = HDR; (m0 + i) < mosi_q.size(); i++) if (mosi_q[m0 + i] != 8'h00) bad++;
    chk("mosi_dummies_zero", 64'(bad), 64'd0);
    chk("toe_roe", 64'({m_toe, m_roe}), 64'd0);
    chk("ss_held", 64'(m_ss_err), 64'd0);
    chk("sso_released", 64'(m_sso), 64'd0);
    if (v.stall_cyc > 0) chk("stall_seen", 64'(stall_done), 64'd1);
  endtask

  vec_t vecs[4];

  initial begin
    int d0, s0, cyc;
    vecs[0] = '{addr: 24'h012345, len: 3, base: 8'hA0, stall_idx: 0, stall_cyc: 0,
                extra_start: 0, exp_hdr: {OPC, 24'h012345, 8'h00}};
    vecs[1] = '{addr: 24'h0ABCDE, len: 4, base: 8'h10, stall_idx: 1, stall_cyc: 50,
                extra_start: 0, exp_hdr: {OPC, 24'h0ABCDE, 8'h00}};
    vecs[2] = '{addr: 24'hFFFFFF, len: 2, base: 8'h55, stall_idx: 0, stall_cyc: 0,
                extra_start: 1, exp_hdr: {OPC, 24'hFFFFFF, 8'h00}};
    vecs[3] = '{addr: 24'h000010, len: 2, base: 8'hC0, stall_idx: 0, stall_cyc: 0,
                extra_start: 0, exp_hdr: {OPC, 24'h000010, 8'h00}};

    reset_n = 1'b0; start = 1'b0; flash_addr = '0; length = '0; out_ready = 1'b1;
    flash_base = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_select", 64'(spi_select), 64'd0);
    chk("rst_read_n", 64'(spi_read_n), 64'd1);
    chk("rst_write_n", 64'(spi_write_n), 64'd1);
    chk("rst_mem_addr", 64'(spi_mem_addr), 64'd0);
    chk("rst_wdata", 64'(spi_data_from_cpu), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_out", 64'({out_valid, out_data}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Zero length: done the very next cycle, no bus traffic, busy never set.
    d0 = m_done_cnt; s0 = m_sel_cycles;
    @(posedge clk); #1;
    flash_addr = 24'h123456; length = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("len0_done_count", 64'(m_done_cnt - d0), 64'd1);
    chk("len0_no_select", 64'(m_sel_cycles - s0), 64'd0);

    for (int i = 0; i < 4; i++) do_xfer(vecs[i]);

    // Reset while the first of eight payload bytes is waiting on the stream.
    flash_base = 8'h30; out_ready = 1'b0;
    @(posedge clk); #1;
    flash_addr = 24'h000100; length = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_valid_seen", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_strobes", 64'({spi_select, spi_read_n, spi_write_n}), 64'b011);
    reset_n = 1'b1;
    out_ready = 1'b1;
    do_xfer(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Command sequencer that sits directly upstream of the Avalon-style SPI master (8-bit, CPOL0/CPHA0) and drives its register port.
- On a start pulse it:
  - asserts slave select via the control register SSO bit,
  - shifts out a flash READ command plus a 24-bit address,
  - reads back N payload bytes and presents them on a valid/ready byte stream,
  - releases SSO.
- Used by the boot/test path to pull flash contents without CPU involvement.

Parameters:
- LEN_W, 16, width of the byte-count input; max transfer is 2^LEN_W-1 bytes.
- READ_OPCODE, 8'h03, opcode sent in the first byte.

Ports:
- clk  in  1  system clock, single domain.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; ignored while busy=1.
- flash_addr  in  24  start address; sent MSB byte first, sampled on start.
- length  in  LEN_W  payload byte count; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sequence has completed.
- out_data  out  8  received payload byte.
- out_valid  out  1  out_data valid; held until out_ready.
- out_ready  in  1  downstream accept.
- spi_select  out  1  chip-select to the SPI core register port.
- spi_mem_addr  out  3  register index (0 rx, 1 tx, 3 control).
- spi_read_n  out  1  active-low read.
- spi_write_n  out  1  active-low write.
- spi_data_from_cpu  out  16  write data.
- spi_data_to_cpu  in  16  read data; registered in the core.
- spi_dataavailable  in  1  core RRDY.
- spi_readyfordata  in  1  core TRDY.

Behaviour:
- Reset: all bus outputs idle (spi_select=0, spi_read_n=1, spi_write_n=1, spi_mem_addr=0, spi_data_from_cpu=0); busy=0, done=0, out_valid=0, out_data=0; FSM=IDLE.
- Bus access: every access holds select/strobe, address and data stable for exactly 2 cycles, then returns idle for at least 1 cycle. On reads, spi_data_to_cpu[7:0] is captured at the end of cycle 2.
- FSM states and transitions:
  - IDLE: on start, latch inputs.
    - If length==0: done pulses the next cycle, no bus traffic, busy stays 0.
    - Otherwise: busy=1, go to SSO_ON.
  - SSO_ON: write addr 3 = 16'h0400. Then load header byte counter hdr=0 and go to WAIT_TRDY.
  - WAIT_TRDY: wait for spi_readyfordata=1, then go to WR_TX.
  - WR_TX: write addr 1. Data is the header byte (opcode, A[23:16], A[15:8], A[7:0]) while in the header, else 8'h00 dummy. Then go to WAIT_RRDY.
  - WAIT_RRDY: wait for spi_dataavailable=1, then go to RD_RX.
  - RD_RX: read addr 0.
    - Header byte: discard it. Next state is WAIT_TRDY.
    - Payload byte: load out_data and set out_valid=1. Next state is EMIT.
  - EMIT: hold until out_ready=1. Decrement the remaining count. Next state is WAIT_TRDY while remaining!=0, else SSO_OFF.
  - SSO_OFF: write addr 3 = 16'h0000, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Exactly one byte is in flight at a time, so the core never sees TOE or ROE.
- out_valid=1 && out_ready=1 in the same cycle counts as a transfer. out_valid is never asserted outside EMIT.
- The remaining counter is LEN_W bits and never wraps. length = 2^LEN_W-1 is legal.
- start asserted together with done, or while busy, is dropped.
- Synchronous reset mid-sequence returns to IDLE immediately with the bus idle. The SPI core must be reset alongside to release SS.

Optional Feature:
- SPI_FAST_READ_EN.
  - Defined: opcode is 8'h0B and the header is 5 bytes (opcode, 3 address bytes, one 8'h00 dummy), all 5 discarded.
  - Undefined: opcode is READ_OPCODE and the header is 4 bytes.

Decomposition:
- Shared package spi_flash_pkg:
  - state enum,
  - register index constants (REG_RX=0, REG_TX=1, REG_CTRL=3),
  - CTRL_SSO=16'h0400,
  - header-length constant.
- One sub-module: spi_reg_access. It runs the 2-cycle read/write handshake, takes req/we/addr/wdata and returns ack/rdata. The FSM stays in spi_flash_reader.

Test Plan:
- start, addr 24'h012345, length 3, against the SPI core model with a flash model returning 8'hA0,A1,A2 → MOSI shows 03 01 23 45 00 00 00; stream gives A0,A1,A2; SS_n low throughout; one done pulse; busy deasserted.
- length 0 → done 1 cycle after start; zero spi_select cycles.
- out_ready held low 50 cycles on byte 2 of 4 → no tx write issued during the stall; all 4 bytes are correct; core TOE=ROE=0.
- start pulsed while busy → ignored; only the original length of bytes is delivered.
- reset_n low mid-payload (byte 1 of 8) → next cycle FSM IDLE, spi_read_n=spi_write_n=1, out_valid=0, busy=0; a fresh start completes normally.
- SPI_FAST_READ_EN defined, addr 24'h000010, length 2 → MOSI 0B 00 00 10 00 00 00; first 5 rx bytes discarded; 2 bytes streamed.
